// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a valid/ready request side and a
// valid/ready result side.
//
// Ops 0-9 (ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA) finish in one
// cycle. Ops 10-15 (MUL, MULHU, DIV, DIVU, REM, REMU) use an iterative
// datapath when the SEQ_ALU_MULDIV_EN macro is defined:
//   - Multiplication is unsigned shift-add, one bit per cycle.
//   - Division is restoring division on operand magnitudes.
//   - Divide-by-zero and signed overflow are resolved in one cycle.
// Without the macro, the iterative datapath and the MUL/DIV states are not
// built. Ops 10-15 then return 0 in one cycle, and eq is still computed.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - request present (op, a, b captured on accept)
//   in_ready   - block can accept a request this cycle
//   op[3:0]    - operation select
//   a, b       - operands, DATA_WIDTH bits
//   out_valid  - result held (DONE state)
//   out_ready  - consumer accepts the held result
//   result     - registered result
//   eq         - registered (a == b) of the request behind result
module seq_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  eq
);

  localparam int W   = DATA_WIDTH;
  localparam int SHW = $clog2(W);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIV   = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_REM   = 4'd14;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`else
  typedef enum logic [0:0] {IDLE, DONE} state_t;
`endif

  state_t         r_state;
  state_t         w_state_next;
  state_t         w_dest;        // state a request accepted this cycle goes to
  logic           w_accept;
  logic [W-1:0]   w_fast_result;
  logic [SHW-1:0] w_shamt;
  logic [W-1:0]   r_result;
  logic           r_eq;

  assign w_shamt  = b[SHW-1:0];
  // Derived straight from the state register so the FSM block never reads its own outputs.
  assign w_accept = in_valid && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
  assign result   = r_result;
  assign eq       = r_eq;

`ifdef SEQ_ALU_MULDIV_EN
  localparam int           CW      = SHW + 1;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic [CW-1:0]  r_cnt;
  logic [3:0]     r_op;
  logic [W-1:0]   r_opnd;        // multiplicand (MUL) or divisor magnitude (DIV)
  logic [2*W-1:0] r_acc;         // {partial product | remainder, multiplier | quotient}
  logic           r_neg_q;
  logic           r_neg_r;

  logic           w_last;
  logic           w_signed_div;
  logic           w_a_neg;
  logic           w_b_neg;
  logic [W-1:0]   w_a_mag;
  logic [W-1:0]   w_b_mag;
  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_next;
  logic [W-1:0]   w_mul_res;
  logic [W:0]     w_div_shift;
  logic [W-1:0]   w_div_diff;
  logic           w_div_ge;
  logic [2*W-1:0] w_div_next;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;
  logic [W-1:0]   w_div_res;

  assign w_last       = (r_cnt == CW'(W - 1));
  assign w_signed_div = (op == OP_DIV) || (op == OP_REM);
  assign w_a_neg      = w_signed_div && a[W-1];
  assign w_b_neg      = w_signed_div && b[W-1];
  assign w_a_mag      = w_a_neg ? -a : a;
  assign w_b_mag      = w_b_neg ? -b : b;

  // Shift-add step: the multiplier LSB in r_acc[0] gates the add into the upper half,
  // then the whole accumulator moves right one bit.
  assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};
  assign w_mul_res  = (r_op == OP_MULHU) ? w_mul_next[2*W-1:W] : w_mul_next[W-1:0];

  // Restoring step: shift the next dividend bit into the remainder, subtract when it
  // fits, and shift the quotient bit in at the bottom.
  assign w_div_shift = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_diff  = w_div_shift[W-1:0] - r_opnd;   // fits W bits whenever w_div_ge
  assign w_div_next  = {(w_div_ge ? w_div_diff : w_div_shift[W-1:0]), r_acc[W-2:0], w_div_ge};
  assign w_quo       = w_div_next[W-1:0];
  assign w_rem       = w_div_next[2*W-1:W];
  assign w_div_res   = ((r_op == OP_DIV) || (r_op == OP_DIVU)) ?
                       (r_neg_q ? -w_quo : w_quo) : (r_neg_r ? -w_rem : w_rem);
`endif

  // Single-cycle result and destination state for the request on the inputs.
  always_comb begin
    w_fast_result = '0;
    w_dest        = DONE;
    case (op)
      OP_ADD:  w_fast_result = a + b;
      OP_SUB:  w_fast_result = a - b;
      OP_AND:  w_fast_result = a & b;
      OP_OR:   w_fast_result = a | b;
      OP_XOR:  w_fast_result = a ^ b;
      OP_SLT:  w_fast_result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_fast_result = {{(W-1){1'b0}}, (a < b)};
      OP_SLL:  w_fast_result = a << w_shamt;
      OP_SRL:  w_fast_result = a >> w_shamt;
      OP_SRA:  w_fast_result = $signed(a) >>> w_shamt;
      default: begin
`ifdef SEQ_ALU_MULDIV_EN
        if ((op == OP_MUL) || (op == OP_MULHU)) begin
          w_dest = MUL;
        end else if (b == '0) begin
          w_fast_result = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : a;
        end else if (w_signed_div && (a == MIN_NEG) && (b == '1)) begin
          w_fast_result = (op == OP_DIV) ? a : '0;
        end else begin
          w_dest = DIV;
        end
`else
        w_fast_result = '0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = w_dest;
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      MUL, DIV: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
`endif
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          w_state_next = in_valid ? w_dest : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_eq     <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      r_cnt    <= '0;
      r_op     <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_eq <= (a == b);
      if (w_dest == DONE) begin
        r_result <= w_fast_result;
      end
`ifdef SEQ_ALU_MULDIV_EN
      // Operands are latched here so later input changes cannot reach the iteration.
      r_cnt <= '0;
      r_op  <= op;
      if (w_dest == MUL) begin
        r_opnd  <= a;
        r_acc   <= {{W{1'b0}}, b};
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else begin
        r_opnd  <= w_b_mag;
        r_acc   <= {{W{1'b0}}, w_a_mag};
        r_neg_q <= w_a_neg ^ w_b_neg;
        r_neg_r <= w_a_neg;
      end
`endif
    end
`ifdef SEQ_ALU_MULDIV_EN
    else if (r_state == MUL) begin
      r_acc <= w_mul_next;
      r_cnt <= r_cnt + CW'(1);
      // The last iteration also writes the result, so DONE follows directly.
      if (w_last) begin
        r_result <= w_mul_res;
      end
    end else if (r_state == DIV) begin
      r_acc <= w_div_next;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_result <= w_div_res;
      end
    end
`endif
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width in bits (legal: 8, 16, 32, 64).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  block can accept request.
REQ-006 SHALL have port op  input  4  operation select, encoding per REQ-012.
REQ-007 SHALL have ports a, b  input  DATA_WIDTH  operands.
REQ-008 SHALL have port out_valid  output  1  result held.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port result  output  DATA_WIDTH  registered result.
REQ-011 SHALL have port eq  output  1  registered (a == b) of the request that produced result.

Function
REQ-012 op SHALL decode as: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low half), 11 MULHU (high half, unsigned), 12 DIV, 13 DIVU, 14 REM, 15 REMU.
REQ-013 Request accepted on a rising edge where in_valid && in_ready; a, b, op captured at that edge.
REQ-014 States SHALL be IDLE, MUL, DIV, DONE; in_ready = (IDLE) || (DONE && out_ready).
REQ-015 Ops 0-9 and shortcut cases (REQ-019, REQ-020): accepted at edge N -> DONE with result valid after edge N+1.
REQ-016 Shift amount SHALL be b[log2(DATA_WIDTH)-1:0]; upper bits ignored.
REQ-017 MUL/MULHU: unsigned shift-add, one bit per cycle, DATA_WIDTH iterations in MUL; result valid after edge N+DATA_WIDTH+1; 2*DATA_WIDTH product, low or high half selected.
REQ-018 DIV/DIVU/REM/REMU: restoring division on magnitudes, DATA_WIDTH iterations in DIV; signed ops negate quotient if signs differ, remainder takes dividend sign; result valid after edge N+DATA_WIDTH+1.
REQ-019 Divide by zero: DIV/DIVU -> all ones; REM/REMU -> a; 1-cycle latency.
REQ-020 Signed overflow (a = most-negative, b = -1): DIV -> a; REM -> 0; 1-cycle latency.
REQ-021 DONE: out_valid = 1; result and eq SHALL hold stable until out_ready sampled high.
REQ-022 DONE with out_ready && in_valid: accepts new request same edge (back-to-back, no bubble for 1-cycle ops).
REQ-023 DONE with out_ready && !in_valid -> IDLE, out_valid deasserts next cycle.
REQ-024 In MUL/DIV, in_ready = 0, in_valid ignored; operand changes after acceptance SHALL NOT affect result.
REQ-025 out_valid SHALL NOT assert in IDLE, MUL or DIV.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, out_valid = 0, result = 0, eq = 0, iteration counter = 0, regardless of clk.
REQ-027 Reset mid-iteration SHALL abandon the operation; no result is produced after rst_n rises.
REQ-028 First request SHALL be acceptable on the first rising edge with rst_n high.

Configuration
REQ-029 Macro SEQ_ALU_MULDIV_EN defined: ops 10-15 behave per REQ-017 to REQ-020, MUL/DIV states and datapath present.
REQ-030 Macro SEQ_ALU_MULDIV_EN undefined: MUL/DIV states and datapath SHALL be absent; ops 10-15 return result = 0, eq as normal, 1-cycle latency.

Verification
REQ-031 DATA_WIDTH=32, ADD a=0xFFFFFFFF b=1, out_ready=1 -> result 0x00000000, eq 0, out_valid one cycle after accept.
REQ-032 SLT a=0xFFFFFFFE b=1 -> 1; SLTU same operands -> 0; SRA a=0x80000000 b=0x21 -> 0xC0000000.
REQ-033 MUL a=0x10000 b=0x10000 -> 0; MULHU same -> 0x00000001; out_valid exactly 33 cycles after accept; in_ready low meanwhile.
REQ-034 DIV a=-7 b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=5 b=0 -> 0xFFFFFFFF (1 cycle); DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-035 ADD completes, out_ready held low 5 cycles -> result stable, in_ready 0; then out_ready=1 with in_valid=1 (OR) -> new result next cycle, no bubble.
REQ-036 DIVU started, rst_n pulsed low at iteration 10 -> out_valid 0 immediately, no result emitted; next ADD after release completes normally.
